// File: rtl/wishbone_master.sv
// Classic Wishbone initiator: one strobe-until-ack cycle per request, with an ack timeout.
// Latency: rsp_valid follows the ack edge; req_ready is low from accept until RESP ends.
module wishbone_master #(
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_adr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  we_o,
  output logic                  adr_o,
  output logic                  strobe,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  ack_i,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                  rdy_q, rdy_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic                  adr_q, adr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic                  rv_q, rv_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rv_d    = 1'b0;
    rdat_d  = rdat_q;
    err_d   = err_q;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        // rdy_q gates acceptance so the first cycle after reset never accepts
        if (req_valid && rdy_q) begin
          state_d = S_BUS;
          cnt_d   = '0;
          stb_d   = 1'b1;
          we_d    = req_we;
          adr_d   = req_adr;
          wdat_d  = req_data;
        end
      end
      S_BUS: begin
        cnt_d = cnt_inc;
        if (ack_i) begin
          state_d = S_RESP;
          stb_d   = 1'b0;
          rv_d    = 1'b1;
          rdat_d  = we_q ? '0 : wb_data_i;
          err_d   = 1'b0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = S_RESP;
          stb_d   = 1'b0;
          rv_d    = 1'b1;
          rdat_d  = '0;
          err_d   = 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        stb_d   = 1'b0;
      end
    endcase

    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 1'b0;
      wdat_q  <= '0;
      rv_q    <= 1'b0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rv_q    <= rv_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = rdy_q;
  assign strobe    = stb_q;
  assign we_o      = we_q;
  assign adr_o     = adr_q;
  assign wb_data_o = wdat_q;
  assign rsp_valid = rv_q;
  assign rsp_data  = rdat_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Bench for wishbone_master: transaction-level reference model checked every cycle,
// plus directed requests with hand-computed literal results.
module tb_wishbone_master;

  localparam int DW = 64;
  localparam int TO = 16;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic          req_adr;
  logic [DW-1:0] req_data;
  logic          we_o;
  logic          adr_o;
  logic          strobe;
  logic [DW-1:0] wb_data_o;
  logic [DW-1:0] wb_data_i;
  logic          ack_i;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  wishbone_master #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_data(req_data),
    .we_o(we_o), .adr_o(adr_o), .strobe(strobe), .wb_data_o(wb_data_o),
    .wb_data_i(wb_data_i), .ack_i(ack_i),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference model: a request is "in flight" for some number of bus cycles (age);
  // it ends on the first sampled ack, or as an error once TIMEOUT cycles have elapsed.
  logic          started;
  logic          m_busy, m_rv, m_ready, m_we, m_adr, m_err;
  logic [DW-1:0] m_wdat, m_rdat;
  int            m_age;
  logic          n_busy, n_rv, n_ready, n_we, n_adr, n_err;
  logic [DW-1:0] n_wdat, n_rdat;
  int            n_age;

  always_comb begin
    n_busy = m_busy; n_rv = 1'b0; n_we = m_we; n_adr = m_adr; n_err = m_err;
    n_wdat = m_wdat; n_rdat = m_rdat; n_age = m_age; n_ready = 1'b0;
    if (reset) begin
      n_busy = 1'b0; n_we = 1'b0; n_adr = 1'b0; n_err = 1'b0;
      n_wdat = '0; n_rdat = '0; n_age = 0;
    end else begin
      if (m_busy) begin
        n_age = m_age + 1;
        if (ack_i) begin
          n_busy = 1'b0; n_rv = 1'b1; n_err = 1'b0;
          n_rdat = m_we ? '0 : wb_data_i;
        end else if (n_age >= TO) begin
          n_busy = 1'b0; n_rv = 1'b1; n_err = 1'b1; n_rdat = '0;
        end
      end else if (m_ready && req_valid) begin
        n_busy = 1'b1; n_age = 0;
        n_we = req_we; n_adr = req_adr; n_wdat = req_data;
      end
      n_ready = !n_busy && !n_rv;
    end
  end

  initial started = 1'b0;
  always @(posedge clock) begin
    started <= started | reset;
    m_busy  <= n_busy;  m_rv   <= n_rv;   m_ready <= n_ready;
    m_we    <= n_we;    m_adr  <= n_adr;  m_err   <= n_err;
    m_wdat  <= n_wdat;  m_rdat <= n_rdat; m_age   <= n_age;
  end

  always @(negedge clock) begin
    if (started) begin
      check("cyc_req_ready", req_ready, m_ready);
      check("cyc_strobe", strobe, m_busy);
      check("cyc_we_o", we_o, m_we);
      check("cyc_adr_o", adr_o, m_adr);
      check("cyc_wb_data_o", wb_data_o, m_wdat);
      check("cyc_rsp_valid", rsp_valid, m_rv);
      check("cyc_rsp_data", rsp_data, m_rdat);
      check("cyc_rsp_err", rsp_err, m_err);
    end
  end

  // Drives one request; the bench acts as slave, acking on strobe cycle ack_on (0 = never).
  task automatic run_req(input logic we, input logic adr, input logic [DW-1:0] d,
                         input int ack_on, input logic [DW-1:0] rd, input logic hold,
                         output int scyc, output logic rv, output logic [DW-1:0] rdat,
                         output logic rerr);
    int guard;
    req_valid = 1'b1; req_we = we; req_adr = adr; req_data = d;
    guard = 0;
    @(negedge clock);
    while (!strobe && guard < 20) begin
      guard++;
      @(negedge clock);
    end
    if (!strobe) check("accept_timeout", 64'(strobe), 64'd1);
    if (!hold) req_valid = 1'b0;
    scyc = 0;
    while (strobe && guard < 100) begin
      scyc++;
      ack_i     = (scyc == ack_on);
      wb_data_i = (scyc == ack_on) ? rd : 64'h5555_AAAA_5555_AAAA;
      guard++;
      @(negedge clock);
    end
    if (strobe) check("strobe_stuck", 64'(strobe), 64'd0);
    ack_i = 1'b0;
    rv = rsp_valid; rdat = rsp_data; rerr = rsp_err;
  endtask

  int            sc;
  logic          rv, er;
  logic [DW-1:0] rdt;
  int            pulses;

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_adr = 1'b1;
    req_data = 64'hDEAD_BEEF_0123_4567; ack_i = 1'b0; wb_data_i = '0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_strobe", strobe, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_strobe", strobe, 0);

    // write to command register, ack on 2nd strobe cycle
    run_req(1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, sc, rv, rdt, er);
    check("wr_strobe_cycles", 64'(sc), 64'd2);
    check("wr_rsp_valid", rv, 1);
    check("wr_rsp_data", rdt, 64'd0);
    check("wr_rsp_err", er, 0);

    // read data register, ack on 1st strobe cycle
    run_req(1'b0, 1'b0, 64'h1111, 1, 64'h0000_0000_CAFE_F00D, 1'b0, sc, rv, rdt, er);
    check("rd_strobe_cycles", 64'(sc), 64'd1);
    check("rd_rsp_valid", rv, 1);
    check("rd_rsp_data", rdt, 64'h0000_0000_CAFE_F00D);
    check("rd_rsp_err", er, 0);
    @(negedge clock);
    check("rd_ready_after", req_ready, 1);

    // dead slave
    run_req(1'b0, 1'b0, 64'h2222, 0, 64'h0, 1'b0, sc, rv, rdt, er);
    check("to_strobe_cycles", 64'(sc), 64'd16);
    check("to_rsp_valid", rv, 1);
    check("to_rsp_err", er, 1);
    check("to_rsp_data", rdt, 64'd0);

    run_req(1'b0, 1'b1, 64'h3333, 3, 64'h0000_0000_0000_1234, 1'b0, sc, rv, rdt, er);
    check("after_to_cycles", 64'(sc), 64'd3);
    check("after_to_data", rdt, 64'h1234);
    check("after_to_err", er, 0);

    // ack coincides with the timeout edge
    run_req(1'b0, 1'b0, 64'h4444, 16, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, sc, rv, rdt, er);
    check("ack16_cycles", 64'(sc), 64'd16);
    check("ack16_valid", rv, 1);
    check("ack16_err", er, 0);
    check("ack16_data", rdt, 64'hA5A5_A5A5_A5A5_A5A5);

    // stray acks while idle
    repeat (2) @(negedge clock);
    pulses = 0;
    ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (rsp_valid || strobe) pulses++;
    end
    ack_i = 1'b0;
    check("idle_ack_pulses", 64'(pulses), 64'd0);
    check("rsp_data_hold", rsp_data, 64'hA5A5_A5A5_A5A5_A5A5);

    // back-to-back writes, reset during the second one
    run_req(1'b1, 1'b0, 64'h0BAD_F00D_0000_0001, 1, 64'h0, 1'b1, sc, rv, rdt, er);
    check("b2b_first_valid", rv, 1);
    check("b2b_first_err", er, 0);
    req_data = 64'h0BAD_F00D_0000_0002;
    sc = 0;
    while (!strobe && sc < 10) begin
      sc++;
      @(negedge clock);
    end
    check("b2b_second_accept", strobe, 1);
    check("b2b_second_data", wb_data_o, 64'h0BAD_F00D_0000_0002);
    @(negedge clock);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clock);
    check("abort_strobe", strobe, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_wb_data_o", wb_data_o, 64'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (rsp_valid) pulses++;
    end
    check("abort_no_rsp", 64'(pulses), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
